// File: rtl/sd_dat_rx_pkg.sv
// sd_dat_rx_pkg: shared types, register map and CRC helper for the SD DAT receive engine
package sd_dat_rx_pkg;
    typedef enum logic [2:0] {S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END, S_DONE} state_t;
    localparam logic [1:0] ADDR_CTRL  = 2'd0;
    localparam logic [1:0] ADDR_DATA  = 2'd1;
    localparam logic [1:0] ADDR_LEVEL = 2'd2;
    localparam logic [1:0] ADDR_CRC   = 2'd3;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam int CTRL_ARM    = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CLR    = 2;
    localparam int STAT_BUSY     = 0;
    localparam int STAT_IRQ_EN   = 1;
    localparam int STAT_DONE     = 2;
    localparam int STAT_CRC_ERR  = 3;
    localparam int STAT_TIMEOUT  = 4;
    localparam int STAT_OVERFLOW = 5;
    // one serial CRC16 step, data bit xored into the feedback path
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic d);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ d) ? CRC_POLY : 16'h0);
    endfunction
endpackage

// File: rtl/sd_crc16.sv
// sd_crc16: serial CRC16 (x^16+x^12+x^5+1) for one DAT line
module sd_crc16 import sd_dat_rx_pkg::*; (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);
    // shift one bit per enabled tick, clear restarts from zero
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            crc <= '0;
        else if (clr)
            crc <= '0;
        else if (en)
            crc <= crc16_step(crc, din);
endmodule

// File: rtl/de2_115_web_qsys_sd_dat_rx.sv
// de2_115_web_qsys_sd_dat_rx: SD 4-bit DAT receive engine with byte FIFO and Avalon-MM slave
module de2_115_web_qsys_sd_dat_rx import sd_dat_rx_pkg::*; #(
    parameter int BLOCK_BYTES = 512,
    parameter int FIFO_DEPTH  = 16,
    parameter int TIMEOUT     = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sd_clk_rise,
    input  logic [3:0]  dat_in,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        busy,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(2 * BLOCK_BYTES);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic [NW-1:0]     nib_cnt;
    logic [TW-1:0]     to_cnt;
    logic [3:0]        bit_cnt, hi_nib;
    logic [3:0][15:0]  rx_crc, calc_crc;
    logic [5:0]        stat;
    logic done, crc_err, timeout, overflow, irq_en;
    logic wr, rd, arm, clr, data_tick, push, pop, push_ok;
    logic unused_ok;

    assign wr        = chipselect & ~write_n;
    assign rd        = chipselect & ~read_n;
    assign arm       = wr && address == ADDR_CTRL && writedata[CTRL_ARM] && !busy;
    assign clr       = wr && address == ADDR_CTRL && writedata[CTRL_CLR];
    assign data_tick = sd_clk_rise && state == S_DATA;
    assign push      = data_tick && nib_cnt[0];
    assign pop       = rd && address == ADDR_DATA && count != '0;
    assign push_ok   = push && (count != (AW+1)'(FIFO_DEPTH) || pop);
    assign irq       = done & irq_en;
    assign unused_ok = &{1'b0, writedata[31:3]};

    for (genvar i = 0; i < 4; i++) begin : g_crc
        sd_crc16 u_crc (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (arm),
            .en      (data_tick),
            .din     (dat_in[i]),
            .crc     (calc_crc[i])
        );
    end

    // status word as seen by the CPU
    always_comb begin
        stat                = '0;
        stat[STAT_BUSY]     = busy;
        stat[STAT_IRQ_EN]   = irq_en;
        stat[STAT_DONE]     = done;
        stat[STAT_CRC_ERR]  = crc_err;
        stat[STAT_TIMEOUT]  = timeout;
        stat[STAT_OVERFLOW] = overflow;
    end

    // receive FSM: start detect, nibble assembly, CRC capture, end-bit check
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            crc_err  <= 1'b0;
            timeout  <= 1'b0;
            overflow <= 1'b0;
            irq_en   <= 1'b0;
            to_cnt   <= '0;
            nib_cnt  <= '0;
            bit_cnt  <= '0;
            hi_nib   <= '0;
            rx_crc   <= '0;
        end else begin
            if (wr && address == ADDR_CTRL)
                irq_en <= writedata[CTRL_IRQ_EN];
            if (clr)
                {done, crc_err, timeout, overflow} <= '0;
            if (push && !push_ok)
                overflow <= 1'b1;
            if (arm) begin
                state   <= S_WAIT_START;
                busy    <= 1'b1;
                {done, crc_err, timeout, overflow} <= '0;
                to_cnt  <= '0;
                nib_cnt <= '0;
                bit_cnt <= '0;
                rx_crc  <= '0;
            end else if (sd_clk_rise) begin
                case (state)
                    S_WAIT_START:
                        if (dat_in == 4'h0)
                            state <= S_DATA;
                        else if (to_cnt == TW'(TIMEOUT - 1)) begin
                            state   <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            timeout <= 1'b1;
                        end else
                            to_cnt <= to_cnt + 1'b1;
                    S_DATA: begin
                        if (!nib_cnt[0])
                            hi_nib <= dat_in;
                        nib_cnt <= nib_cnt + 1'b1;
                        if (nib_cnt == NW'(2 * BLOCK_BYTES - 1))
                            state <= S_CRC;
                    end
                    S_CRC: begin
                        for (int l = 0; l < 4; l++)
                            rx_crc[l] <= {rx_crc[l][14:0], dat_in[l]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'd15)
                            state <= S_END;
                    end
                    S_END: begin
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        crc_err <= dat_in != 4'hF || rx_crc != calc_crc;
                    end
                    default: ;
                endcase
            end
        end
    end

    // FIFO storage, written only when a completed byte has room
    always_ff @(posedge clk)
        if (push_ok)
            mem[wr_ptr] <= {hi_nib, dat_in};

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_ok);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
        end
    end

    // registered read port, captures state of the request cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata <= '0;
        else if (rd) begin
            case (address)
                ADDR_CTRL:  readdata <= {26'b0, stat};
                ADDR_DATA:  readdata <= pop ? {23'b0, 1'b1, mem[rd_ptr]} : 32'b0;
                ADDR_LEVEL: readdata <= 32'(count);
                default:    readdata <= {16'b0, rx_crc[0]};
            endcase
        end
    end
endmodule

// File: tb/tb_de2_115_web_qsys_sd_dat_rx.sv
// tb_de2_115_web_qsys_sd_dat_rx: directed bench with behavioural model for the SD DAT receiver
module tb_de2_115_web_qsys_sd_dat_rx;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rise = 1'b0;
    logic [3:0]  dat = 4'hF;
    logic [1:0]  address = 2'd0;
    logic [1:0]  cs = 2'b00;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata [2];
    logic        busy [2];
    logic        irq [2];
    logic        run = 1'b0;
    int tests = 0;
    int fails = 0;

    logic [7:0] blk [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    int   dep [2] = '{16, 2};
    logic m_busy [2], m_done [2], m_ien [2], m_crcerr [2], m_to [2], m_ovf [2];
    logic [7:0] mq [2][16];
    int   mhead [2], mcnt [2];

    always #5 clk = ~clk;

    de2_115_web_qsys_sd_dat_rx #(.BLOCK_BYTES(4), .FIFO_DEPTH(16), .TIMEOUT(200)) dut_a (
        .clk(clk), .reset_n(reset_n), .sd_clk_rise(rise), .dat_in(dat), .address(address),
        .chipselect(cs[0]), .read_n(read_n), .write_n(write_n), .writedata(wdata),
        .readdata(rdata[0]), .busy(busy[0]), .irq(irq[0]));

    de2_115_web_qsys_sd_dat_rx #(.BLOCK_BYTES(4), .FIFO_DEPTH(2), .TIMEOUT(10)) dut_b (
        .clk(clk), .reset_n(reset_n), .sd_clk_rise(rise), .dat_in(dat), .address(address),
        .chipselect(cs[1]), .read_n(read_n), .write_n(write_n), .writedata(wdata),
        .readdata(rdata[1]), .busy(busy[1]), .irq(irq[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // every cycle: busy and irq of both engines against the model
    always @(negedge clk)
        if (run)
            for (int d = 0; d < 2; d++) begin
                check($sformatf("busy%0d", d), 32'(busy[d]), 32'(m_busy[d]));
                check($sformatf("irq%0d", d), 32'(irq[d]), 32'(m_done[d] & m_ien[d]));
            end

    // reference CRC: remainder of msg(x)*x^16 mod G(x) by long division
    function automatic logic [15:0] line_crc(input int l);
        logic [23:0] r;
        logic [7:0]  m;
        logic [3:0]  n;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            n = (i % 2 == 1) ? blk[i/2][3:0] : blk[i/2][7:4];
            m = {m[6:0], n[l]};
        end
        r = {m, 16'h0};
        for (int k = 23; k >= 16; k--)
            if (r[k])
                r[k-:17] = r[k-:17] ^ 17'h11021;
        return r[15:0];
    endfunction

    function automatic void model_clear_flags(input int d);
        m_done[d] = 0; m_crcerr[d] = 0; m_to[d] = 0; m_ovf[d] = 0;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            model_clear_flags(d);
            m_busy[d] = 0; m_ien[d] = 0; mhead[d] = 0; mcnt[d] = 0;
        end
    endfunction

    function automatic void model_push(input int d, input logic [7:0] b);
        if (mcnt[d] < dep[d]) begin
            mq[d][(mhead[d] + mcnt[d]) % 16] = b;
            mcnt[d]++;
        end else
            m_ovf[d] = 1;
    endfunction

    function automatic logic [31:0] model_pop(input int d);
        logic [31:0] v;
        if (mcnt[d] == 0)
            return 32'd0;
        v = {23'd0, 1'b1, mq[d][mhead[d]]};
        mhead[d] = (mhead[d] + 1) % 16;
        mcnt[d]--;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ctrl_write(input int d, input logic [31:0] val);
        address = 2'd0; wdata = val; write_n = 1'b0; cs[d] = 1'b1;
        step();
        write_n = 1'b1; cs = 2'b00;
        m_ien[d] = val[1];
        if (val[2])
            model_clear_flags(d);
        if (val[0] && !m_busy[d]) begin
            m_busy[d] = 1;
            model_clear_flags(d);
        end
    endtask

    task automatic rd(input int d, input logic [1:0] a, output logic [31:0] v);
        address = a; read_n = 1'b0; cs[d] = 1'b1;
        step();
        read_n = 1'b1; cs = 2'b00;
        v = rdata[d];
    endtask

    task automatic stat_check(input int d, input string name, input logic [31:0] lit);
        logic [31:0] v;
        rd(d, 2'd0, v);
        check(name, v, {26'd0, m_ovf[d], m_to[d], m_crcerr[d], m_done[d], m_ien[d], m_busy[d]});
        check({name, "_lit"}, v, lit);
    endtask

    task automatic pop_check(input int d, input string name, input logic [31:0] lit);
        logic [31:0] v;
        rd(d, 2'd1, v);
        check(name, v, model_pop(d));
        check({name, "_lit"}, v, lit);
    endtask

    task automatic level_check(input int d, input string name, input logic [31:0] lit);
        logic [31:0] v;
        rd(d, 2'd2, v);
        check(name, v, 32'(mcnt[d]));
        check({name, "_lit"}, v, lit);
    endtask

    // one SD clock tick, optionally with a DATA read in the same clk cycle
    task automatic tick(input logic [3:0] n, input int pd);
        dat = n; rise = 1'b1;
        if (pd >= 0) begin
            address = 2'd1; read_n = 1'b0; cs[pd] = 1'b1;
        end
        step();
        rise = 1'b0; read_n = 1'b1; cs = 2'b00;
    endtask

    task automatic send_block(input int d, input int flip, input int pop_nib, input int idle);
        logic [15:0] c [4];
        logic [3:0]  n;
        for (int i = 0; i < idle; i++) begin
            tick(4'hF, -1);
            step();
        end
        tick(4'h0, -1);
        step();
        for (int i = 0; i < 8; i++) begin
            n = (i % 2 == 1) ? blk[i/2][3:0] : blk[i/2][7:4];
            tick(n, pop_nib == i ? d : -1);
            if (pop_nib == i)
                check("same_cycle_pop", rdata[d], model_pop(d));
            if (i % 2 == 1)
                model_push(d, blk[i/2]);
            step();
        end
        for (int l = 0; l < 4; l++)
            c[l] = line_crc(l);
        if (flip >= 0)
            c[flip][9] = ~c[flip][9];
        for (int k = 15; k >= 0; k--) begin
            tick({c[3][k], c[2][k], c[1][k], c[0][k]}, -1);
            step();
        end
        tick(4'hF, -1);
        m_busy[d] = 0; m_done[d] = 1; m_crcerr[d] = (flip >= 0);
        step();
    endtask

    initial begin
        logic [31:0] v;
        model_reset();
        repeat (3) step();
        check("reset_rdata_a", rdata[0], 32'd0);
        check("reset_busy_b", 32'(busy[1]), 32'd0);
        reset_n = 1'b1;
        run = 1'b1;
        step();

        // timeout on the short-timeout engine
        ctrl_write(1, 32'h1);
        for (int t = 1; t <= 10; t++) begin
            tick(4'hF, -1);
            if (t == 10) begin
                m_busy[1] = 0; m_done[1] = 1; m_to[1] = 1;
            end
            step();
        end
        stat_check(1, "timeout_stat", 32'h14);
        level_check(1, "timeout_level", 32'd0);

        // overflow with a 2-deep FIFO, no pops during reception
        ctrl_write(1, 32'h1);
        send_block(1, -1, -1, 3);
        level_check(1, "ovf_level", 32'd2);
        stat_check(1, "ovf_stat", 32'h24);
        pop_check(1, "ovf_pop0", 32'h112);
        pop_check(1, "ovf_pop1", 32'h134);
        pop_check(1, "ovf_empty", 32'h0);

        // clean block with irq enabled, long idle before start bit
        ctrl_write(0, 32'h3);
        send_block(0, -1, -1, 100);
        check("irq_a_lit", 32'(irq[0]), 32'd1);
        stat_check(0, "clean_stat", 32'h06);
        rd(0, 2'd3, v);
        check("crc_rx", v, {16'd0, line_crc(0)});
        check("crc_rx_lit", v, 32'h14A0);
        level_check(0, "clean_level", 32'd4);
        pop_check(0, "clean_pop0", 32'h112);
        pop_check(0, "clean_pop1", 32'h134);
        pop_check(0, "clean_pop2", 32'h156);
        pop_check(0, "clean_pop3", 32'h178);
        pop_check(0, "clean_empty", 32'h0);

        // CRC bit flipped on line 2, pop concurrent with third byte push, arm while busy
        ctrl_write(0, 32'h3);
        ctrl_write(0, 32'h3);
        send_block(0, 2, 5, 4);
        stat_check(0, "crcerr_stat", 32'h0E);
        level_check(0, "crcerr_level", 32'd3);
        pop_check(0, "crcerr_pop1", 32'h134);
        pop_check(0, "crcerr_pop2", 32'h156);
        pop_check(0, "crcerr_pop3", 32'h178);
        pop_check(0, "crcerr_empty", 32'h0);

        // clear flags keeps irq_en
        ctrl_write(0, 32'h6);
        stat_check(0, "clear_stat", 32'h02);

        // reset in the middle of DATA
        ctrl_write(0, 32'h1);
        tick(4'hF, -1); step();
        tick(4'h0, -1); step();
        tick(4'h1, -1); step();
        tick(4'h2, -1); model_push(0, 8'h12); step();
        tick(4'h3, -1); step();
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_rdata", rdata[0], 32'd0);
        check("rst_irq", 32'(irq[0]), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        level_check(0, "rst_level", 32'd0);
        stat_check(0, "rst_stat", 32'h00);
        ctrl_write(0, 32'h1);
        send_block(0, -1, -1, 2);
        stat_check(0, "rearm_stat", 32'h04);
        pop_check(0, "rearm_pop0", 32'h112);
        pop_check(0, "rearm_pop1", 32'h134);
        pop_check(0, "rearm_pop2", 32'h156);
        pop_check(0, "rearm_pop3", 32'h178);
        pop_check(0, "rearm_empty", 32'h0);

        run = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
